// File: rtl/mul_wb_stage_pkg.sv
// Shared types and default widths for the multiplier write-back stage.
package mul_wb_stage_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/mul_wb_stage_if.sv
// Handshake bundle: multiplier result in, register-file write out.
interface mul_wb_stage_if
  import mul_wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] mul_out;
  logic              ci_mul;
  logic [ADDR_W-1:0] in_addr;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output in_valid, mul_out, ci_mul, in_addr, wb_ready,
    input  in_ready, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  in_valid, mul_out, ci_mul, in_addr, wb_ready,
    output in_ready, wb_valid, wb_addr, wb_data
  );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry in-order write-back FIFO; ready is registered so it never depends on pop_ready.
module wb_fifo2
  import mul_wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [ADDR_W-1:0] pop_addr,
  output logic [DATA_W-1:0] pop_data
);

  localparam logic [1:0] EMPTY = FIFO_EMPTY;
  localparam logic [1:0] ONE   = FIFO_ONE;
  localparam logic [1:0] FULL  = FIFO_FULL;

  logic [1:0]        state_reg, state_next;
  logic              rd_ptr_reg, wr_ptr_reg;
  logic              ready_reg;
  logic              push, pop;
  logic [ADDR_W-1:0] addr_mem [2];
  logic [DATA_W-1:0] data_mem [2];

  assign push = push_valid & ready_reg;
  assign pop  = (state_reg != EMPTY) & pop_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
      end
      FULL:  if (pop) state_next = ONE;
      default: state_next = state_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= EMPTY;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      ready_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ready_reg  <= (state_next != FULL);
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // Entries are cleared on reset so the write-back bus idles at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (push) begin
      addr_mem[wr_ptr_reg] <= push_addr;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  assign push_ready = ready_reg;
  assign pop_valid  = (state_reg != EMPTY);
  assign pop_addr   = addr_mem[rd_ptr_reg];
  assign pop_data   = data_mem[rd_ptr_reg];

endmodule

// File: rtl/mul_wb_stage.sv
// Multiplier write-back stage: result flags/accumulator plus buffered register-file write.
// Optional sticky overflow flag enabled by defining MUL_WB_OVF_STICKY_EN.
module mul_wb_stage
  import mul_wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mul_wb_stage_if.slave     bus,
  output logic [DATA_W-1:0] acc_q,
  output logic              carry_flag,
  output logic              zero_flag
`ifdef MUL_WB_OVF_STICKY_EN
  ,
  input  logic              clr_ovf,
  output logic              ovf_sticky
`endif
);

  logic              accept;
  logic [DATA_W-1:0] acc_reg;
  logic              carry_reg, zero_reg;

  assign accept = bus.in_valid & bus.in_ready;

  wb_fifo2 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (bus.in_valid),
    .push_ready (bus.in_ready),
    .push_addr  (bus.in_addr),
    .push_data  (bus.mul_out),
    .pop_valid  (bus.wb_valid),
    .pop_ready  (bus.wb_ready),
    .pop_addr   (bus.wb_addr),
    .pop_data   (bus.wb_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
    end else if (accept) begin
      acc_reg   <= bus.mul_out;
      carry_reg <= bus.ci_mul;
      zero_reg  <= (bus.mul_out == '0);
    end
  end

  assign acc_q      = acc_reg;
  assign carry_flag = carry_reg;
  assign zero_flag  = zero_reg;

`ifdef MUL_WB_OVF_STICKY_EN
  logic ovf_reg;

  // A new overflow takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)                  ovf_reg <= 1'b0;
    else if (accept && bus.ci_mul) ovf_reg <= 1'b1;
    else if (clr_ovf)            ovf_reg <= 1'b0;
  end

  assign ovf_sticky = ovf_reg;
`endif

endmodule

// File: doc/mul_wb_stage.md
MUL_WB_STAGE -- requirements
Module: mul_wb_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the width of the multiplier result and the write-back data.
REQ-002 The block SHALL have parameter ADDR_W, default 3, giving the width of the destination register address.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  is the reset, synchronous and active-low.
REQ-005 Port in_valid  input  1  SHALL mark that the upstream multiplier result is valid.
REQ-006 Port in_ready  output  1  SHALL indicate that the block can accept a result.
REQ-007 Port mul_out  input  DATA_W  SHALL carry the multiplier product low bits.
REQ-008 Port ci_mul  input  1  SHALL carry the multiplier carry-out bit.
REQ-009 Port in_addr  input  ADDR_W  SHALL carry the destination register address.
REQ-010 Port wb_valid  output  1  SHALL mark that a valid register-file write is presented.
REQ-011 Port wb_ready  input  1  SHALL indicate that the register file accepts the write.
REQ-012 Port wb_addr  output  ADDR_W  SHALL carry the write address.
REQ-013 Port wb_data  output  DATA_W  SHALL carry the write data.
REQ-014 Port acc_q  output  DATA_W  SHALL hold the most recently accepted result.
REQ-015 Port carry_flag  output  1  and port zero_flag  output  1  SHALL hold the flags of the most recent accepted result.

Function
REQ-016 A result SHALL be accepted on a cycle where in_valid=1 and in_ready=1.
REQ-017 On acceptance, acc_q<=mul_out, carry_flag<=ci_mul and zero_flag<=(mul_out==0) SHALL take effect at the next edge (1-cycle latency).
REQ-018 Accepted {in_addr, mul_out} SHALL be stored in a 2-entry in-order FIFO.
REQ-019 The FIFO state machine SHALL have states EMPTY, ONE and FULL, all held in registers.
REQ-020 FIFO transitions SHALL be:
- EMPTY->ONE on a push.
- ONE->FULL on a push without a pop.
- ONE->EMPTY on a pop without a push.
- ONE->ONE on simultaneous push and pop.
- FULL->ONE on a pop.
- Any other combination SHALL hold the current state.
REQ-021 in_ready SHALL be 1 only in EMPTY or ONE and SHALL be a registered signal with no combinational path from wb_ready; in FULL a push SHALL NOT occur even if a pop occurs in the same cycle.
REQ-022 wb_valid SHALL be 1 in ONE and FULL, with wb_addr/wb_data showing the oldest entry.
REQ-023 A pop SHALL occur on a cycle where wb_valid=1 and wb_ready=1.
REQ-024 wb_addr and wb_data SHALL remain stable while wb_valid=1 and wb_ready=0.
REQ-025 A write SHALL reach wb_valid no earlier than the cycle after its acceptance; there is no bypass from input to output.
REQ-026 The read and write pointers SHALL be 1 bit each and wrap from 1 to 0.

Reset
REQ-027 While rst_n=0 at a clock edge, the state SHALL go to EMPTY and the pointers to 0.
REQ-028 While rst_n=0 at a clock edge, acc_q, carry_flag, zero_flag, wb_addr and wb_data SHALL go to 0, wb_valid to 0 and in_ready to 0.
REQ-029 in_ready SHALL be 1 on the first cycle after rst_n is released.
REQ-030 A reset asserted mid-operation SHALL discard all buffered entries without emitting a write.

Configuration
REQ-031 When macro MUL_WB_OVF_STICKY_EN is defined, the block SHALL add input clr_ovf (1 bit) and output ovf_sticky (1 bit).
REQ-032 With MUL_WB_OVF_STICKY_EN defined, ovf_sticky SHALL set on any accepted result with ci_mul=1, clear on clr_ovf=1, and reset to 0.
REQ-033 With MUL_WB_OVF_STICKY_EN defined, a set SHALL win over clr_ovf when both occur in the same cycle.
REQ-034 Without MUL_WB_OVF_STICKY_EN, the clr_ovf and ovf_sticky ports and their logic SHALL be absent.

Structure
REQ-035 A shared package SHALL hold the FIFO state enum (EMPTY/ONE/FULL) and the default DATA_W/ADDR_W constants.
REQ-036 The 2-entry FIFO SHALL be implemented as sub-module wb_fifo2; flag and accumulator logic SHALL stay in mul_wb_stage.

Verification
REQ-037 Accept mul_out=0x2A, ci_mul=0, in_addr=3 -> next cycle acc_q=0x2A, carry_flag=0, zero_flag=0, wb_valid=1, wb_addr=3, wb_data=0x2A.
REQ-038 Accept mul_out=0x00, ci_mul=1 -> zero_flag=1, carry_flag=1; with MUL_WB_OVF_STICKY_EN, ovf_sticky=1 until clr_ovf.
REQ-039 Hold wb_ready=0 and push 0x11 then 0x22 -> FULL, in_ready=0, and a third in_valid is not accepted; then set wb_ready=1 -> 0x11 then 0x22 are emitted in order.
REQ-040 In ONE, push 0x33 and pop in the same cycle -> state stays ONE and the next wb_data=0x33.
REQ-041 Assert rst_n=0 in FULL -> next cycle wb_valid=0 and acc_q=0; after release, in_ready=1 and no stale write is emitted.
REQ-042 Random valid/ready stress of 1000 results -> write order and data match the scoreboard with no loss or duplication.
